// File: rtl/prog_mem_pkg.sv
// Shared types and sizing for the program memory and its load sequencer.
// PROG_MEM_CHECKSUM_EN selects the 17-byte checksummed load length.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } prog_mem_state_t;

    localparam int PM_DEPTH  = 16;
    localparam int PM_ADDR_W = 4;
    localparam int PM_DATA_W = 8;
    localparam int PM_WP_W   = 5;

`ifdef PROG_MEM_CHECKSUM_EN
    localparam int PM_LOAD_LEN = 17;
`else
    localparam int PM_LOAD_LEN = 16;
`endif

endpackage

// File: rtl/prog_mem_array.sv
// Program register file: async clear, one synchronous write port,
// one zero-latency combinational read port.
module prog_mem_array #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Registers rather than block RAM: reset has to wipe every word at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/prog_mem.sv
// Program memory with a byte-stream loader that holds the CPU in reset while
// the program is rewritten. PROG_MEM_CHECKSUM_EN adds a trailing checksum byte.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int DEPTH  = PM_DEPTH,
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr,
    output logic              cpu_n_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_error
);

    localparam logic [PM_WP_W-1:0] WP_LAST = PM_WP_W'(PM_LOAD_LEN - 1);

    prog_mem_state_t    state_reg, state_next;
    logic [PM_WP_W-1:0] wp_reg, wp_next;
    logic               accept;
    logic               mem_we;
    logic [DATA_W-1:0]  rdata;

`ifdef PROG_MEM_CHECKSUM_EN
    logic [DATA_W-1:0]  sum_reg, sum_next;
    logic               error_reg, error_next;
`endif

    assign ld_ready    = (state_reg == ST_LOAD);
    assign accept      = ld_valid && ld_ready;
    // The checksum byte sits at wp == DEPTH and must not land in memory.
    assign mem_we      = accept && (wp_reg < PM_WP_W'(DEPTH));
    assign cpu_n_reset = (state_reg == ST_IDLE);
    assign ld_done     = (state_reg == ST_DONE);
    assign instr       = cpu_n_reset ? rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            wp_reg    <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_reg   <= '0;
            error_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            wp_reg    <= wp_next;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_reg   <= sum_next;
            error_reg <= error_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        wp_next    = wp_reg;
`ifdef PROG_MEM_CHECKSUM_EN
        sum_next   = sum_reg;
        error_next = error_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
                    wp_next    = '0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_next   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wp_next = wp_reg + 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
                    if (mem_we) begin
                        sum_next = sum_reg + ld_data;
                    end
                    if (wp_reg == WP_LAST) begin
                        if (ld_data == sum_reg) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_ERR;
                            error_next = 1'b1;
                        end
                    end
`else
                    if (wp_reg == WP_LAST) begin
                        state_next = ST_DONE;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
`ifdef PROG_MEM_CHECKSUM_EN
            ST_ERR: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
                    wp_next    = '0;
                    sum_next   = '0;
                    error_next = 1'b0;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef PROG_MEM_CHECKSUM_EN
    assign ld_error = error_reg;
`else
    assign ld_error = 1'b0;
`endif

    prog_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (wp_reg[ADDR_W-1:0]),
        .wdata (ld_data),
        .raddr (address),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_prog_mem.sv
// Directed/randomized bench for prog_mem against an array model of the program.
module tb_prog_mem;
    import prog_mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] address;
    logic [7:0] instr;
    logic       cpu_n_reset;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       ld_error;

    int checks   = 0;
    int failures = 0;
    int done_count = 0;

    logic [7:0] model_mem [16];
    logic [7:0] ld_bytes  [17];

    prog_mem dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .instr       (instr),
        .cpu_n_reset (cpu_n_reset),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .ld_error    (ld_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_done === 1'b1) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            @(negedge clk);
            check(tag, 32'(instr), 32'(model_mem[a]));
        end
    endtask

    // Runs one load from the current cycle; ends #1 after the edge that leaves
    // DONE (or one cycle into ERR).
    task automatic do_load(input bit throttle, input bit expect_err, input bit poke_done);
        int  i;
        int  guard;
        int  d0;
        bit  v;
        d0 = done_count;
        address  = 4'd5;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("ready_in_load", 32'(ld_ready), 32'd1);
        check("cpu_held_in_load", 32'(cpu_n_reset), 32'd0);
        check("instr_blank_in_load", 32'(instr), 32'd0);
        i = 0;
        guard = 0;
        while (i < PM_LOAD_LEN && guard < 400) begin
            v = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
            ld_valid = v;
            ld_data  = v ? ld_bytes[i] : 8'($urandom);
            ld_start = throttle && ($urandom_range(0, 3) == 0);
            step();
            if (v) i++;
            guard++;
        end
        ld_valid = 1'b0;
        ld_start = 1'b0;
        check("load_byte_count", 32'(i), 32'(PM_LOAD_LEN));
        for (int k = 0; k < 16; k++) model_mem[k] = ld_bytes[k];
        if (expect_err) begin
            check("err_no_done", 32'(ld_done), 32'd0);
            check("err_flag", 32'(ld_error), 32'd1);
            check("err_cpu_held", 32'(cpu_n_reset), 32'd0);
            check("err_not_ready", 32'(ld_ready), 32'd0);
            step();
            check("err_cpu_still_held", 32'(cpu_n_reset), 32'd0);
        end else begin
            check("done_pulse", 32'(ld_done), 32'd1);
            check("done_cpu_held", 32'(cpu_n_reset), 32'd0);
            check("done_not_ready", 32'(ld_ready), 32'd0);
            check("done_no_error", 32'(ld_error), 32'd0);
            ld_start = poke_done;
            step();
            ld_start = 1'b0;
            check("idle_done_low", 32'(ld_done), 32'd0);
            check("idle_cpu_released", 32'(cpu_n_reset), 32'd1);
            check("idle_not_ready", 32'(ld_ready), 32'd0);
            check("done_once", 32'(done_count), 32'(d0 + 1));
            if (poke_done) begin
                step();
                check("start_in_done_ignored", 32'(ld_ready), 32'd0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        address  = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
        #1;
        check("rst_cpu_n_reset", 32'(cpu_n_reset), 32'd1);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        check("rst_ld_error", 32'(ld_error), 32'd0);
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        check_all_mem("rst_mem");
        step();

        // Full load 8'h30+i, then a back-to-back load starting in the first IDLE cycle.
        for (int k = 0; k < 17; k++) ld_bytes[k] = 8'(8'h30 + k);
`ifdef PROG_MEM_CHECKSUM_EN
        ld_bytes[16] = 8'h78;   // 0x30*16 + (0+..+15) = 0x378
`endif
        do_load(1'b0, 1'b0, 1'b0);
        address = 4'd5;
        #1;
        check("full_load_addr5", 32'(instr), 32'h35);
        for (int k = 0; k < 17; k++) ld_bytes[k] = 8'($urandom);
        begin
            logic [7:0] s;
            s = 8'h00;
            for (int k = 0; k < 16; k++) s = s + ld_bytes[k];
            ld_bytes[16] = s;
        end
        do_load(1'b0, 1'b0, 1'b1);
        check_all_mem("b2b_mem");

        // Throttled random load with stray ld_start pulses.
        for (int k = 0; k < 17; k++) ld_bytes[k] = 8'($urandom);
        begin
            logic [7:0] s;
            s = 8'h00;
            for (int k = 0; k < 16; k++) s = s + ld_bytes[k];
            ld_bytes[16] = s;
        end
        do_load(1'b1, 1'b0, 1'b0);
        check_all_mem("throttled_mem");

        // Reset after 7 bytes.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ld_data = 8'($urandom);
            step();
        end
        ld_valid = 1'b0;
        address  = 4'd3;
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
        check("midrst_cpu_n_reset", 32'(cpu_n_reset), 32'd1);
        check("midrst_ready", 32'(ld_ready), 32'd0);
        check("midrst_addr3", 32'(instr), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        check_all_mem("midrst_mem");
        step();

`ifdef PROG_MEM_CHECKSUM_EN
        for (int k = 0; k < 16; k++) ld_bytes[k] = 8'h11;
        ld_bytes[16] = 8'h10;
        do_load(1'b0, 1'b0, 1'b0);
        check_all_mem("cksum_ok_mem");
        ld_bytes[16] = 8'h00;
        do_load(1'b0, 1'b1, 1'b0);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("err_cleared_by_start", 32'(ld_error), 32'd0);
        check("err_restart_ready", 32'(ld_ready), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
